// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register stall codes, fetch-kill after redirects,
// and saturating stall/flush performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  input  logic        ex_busy,
  input  logic        ex_redirect,
  input  logic        id_rs1_rena,
  input  logic        id_rs2_rena,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        ex_mem_to_reg,
  input  logic        ex_rd_wena,
  input  logic [4:0]  ex_rd_waddr,
  input  logic        if_busy,
  input  logic        if_rvalid,
  output logic [1:0]  pc_stall,
  output logic [1:0]  if_id_stall,
  output logic [1:0]  id_ex_stall,
  output logic [1:0]  ex_me_stall,
  output logic [1:0]  me_wb_stall,
  output logic        if_kill,
  output logic [63:0] stall_cnt,
  output logic [63:0] flush_cnt
);

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] NORMAL = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       load_use;
  logic       redirect_acc;
  logic       running;

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == '1) ? v : v + 64'd1;
  endfunction

  assign running  = (state != BOOT);
  assign load_use = ex_mem_to_reg & ex_rd_wena & (ex_rd_waddr != 5'd0) &
                    ((id_rs1_rena & (id_rs1_addr == ex_rd_waddr)) |
                     (id_rs2_rena & (id_rs2_addr == ex_rd_waddr)));

  always_comb begin
    pc_stall     = STALL_ZERO;
    if_id_stall  = STALL_ZERO;
    id_ex_stall  = STALL_ZERO;
    ex_me_stall  = STALL_ZERO;
    me_wb_stall  = STALL_ZERO;
    if_kill      = 1'b0;
    redirect_acc = 1'b0;
    state_nxt    = NORMAL;
    if (running) begin
      // A redirect is only honoured once nothing downstream is holding EX.
      if (mem_busy) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_ZERO};
      end else if (ex_busy) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_KEEP, STALL_KEEP, STALL_KEEP, STALL_ZERO, STALL_NEXT};
      end else if (ex_redirect) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_NEXT, STALL_ZERO, STALL_ZERO, STALL_NEXT, STALL_NEXT};
        redirect_acc = 1'b1;
      end else if (load_use) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_KEEP, STALL_KEEP, STALL_ZERO, STALL_NEXT, STALL_NEXT};
      end else if ((state == DROP) || !if_rvalid) begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_KEEP, STALL_ZERO, STALL_NEXT, STALL_NEXT, STALL_NEXT};
      end else begin
        {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} =
          {STALL_NEXT, STALL_NEXT, STALL_NEXT, STALL_NEXT, STALL_NEXT};
      end

      // The in-flight fetch at redirect time is stale; wait for and discard it.
      if (state == DROP) begin
        if_kill   = if_rvalid;
        state_nxt = (if_rvalid && !redirect_acc) ? NORMAL : DROP;
      end else if (redirect_acc && if_busy && !if_rvalid) begin
        state_nxt = DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (running && (pc_stall != STALL_NEXT))
        stall_cnt <= sat_inc(stall_cnt);
      if (redirect_acc)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a rule-level reference model and literal pins.
module tb_pipe_ctrl;

  localparam logic [1:0] NX = 2'b00;
  localparam logic [1:0] KP = 2'b01;
  localparam logic [1:0] ZR = 2'b10;

  localparam logic [10:0] L_BOOT = {ZR, ZR, ZR, ZR, ZR, 1'b0};
  localparam logic [10:0] L_RUN  = {NX, NX, NX, NX, NX, 1'b0};
  localparam logic [10:0] L_MEMB = {KP, KP, KP, KP, ZR, 1'b0};
  localparam logic [10:0] L_EXB  = {KP, KP, KP, ZR, NX, 1'b0};
  localparam logic [10:0] L_REDI = {NX, ZR, ZR, NX, NX, 1'b0};
  localparam logic [10:0] L_LU   = {KP, KP, ZR, NX, NX, 1'b0};
  localparam logic [10:0] L_WAIT = {KP, ZR, NX, NX, NX, 1'b0};
  localparam logic [10:0] L_KILL = {KP, ZR, NX, NX, NX, 1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy, ex_busy, ex_redirect;
  logic        id_rs1_rena, id_rs2_rena;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        ex_mem_to_reg, ex_rd_wena;
  logic [4:0]  ex_rd_waddr;
  logic        if_busy, if_rvalid;
  logic [1:0]  pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall;
  logic        if_kill;
  logic [63:0] stall_cnt, flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_busy(mem_busy), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .id_rs1_rena(id_rs1_rena), .id_rs2_rena(id_rs2_rena),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rd_wena(ex_rd_wena), .ex_rd_waddr(ex_rd_waddr),
    .if_busy(if_busy), .if_rvalid(if_rvalid),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_me_stall(ex_me_stall), .me_wb_stall(me_wb_stall),
    .if_kill(if_kill), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          m_boot, m_drop;
  logic [63:0] m_stall, m_flush;

  function automatic bit hazard_lu();
    return ex_mem_to_reg && ex_rd_wena && (ex_rd_waddr != 5'd0) &&
           ((id_rs1_rena && id_rs1_addr == ex_rd_waddr) ||
            (id_rs2_rena && id_rs2_addr == ex_rd_waddr));
  endfunction

  // 0 boot, 1 mem_busy, 2 ex_busy, 3 redirect, 4 load-use, 5 fetch wait, 6 run
  function automatic int rule();
    if (m_boot) return 0;
    if (mem_busy) return 1;
    if (ex_busy) return 2;
    if (ex_redirect) return 3;
    if (hazard_lu()) return 4;
    if (m_drop || !if_rvalid) return 5;
    return 6;
  endfunction

  function automatic logic [9:0] codes(input int r);
    case (r)
      1:       return {KP, KP, KP, KP, ZR};
      2:       return {KP, KP, KP, ZR, NX};
      3:       return {NX, ZR, ZR, NX, NX};
      4:       return {KP, KP, ZR, NX, NX};
      5:       return {KP, ZR, NX, NX, NX};
      6:       return {NX, NX, NX, NX, NX};
      default: return {ZR, ZR, ZR, ZR, ZR};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: compare at negedge, then advance the model on the rising edge.
  task automatic tick(input string tag, input bit lit_en, input logic [10:0] lit);
    int         r;
    logic [9:0] act;
    @(negedge clk);
    r   = rule();
    act = {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall};
    chk({tag, ".codes"}, 64'(act), 64'(codes(r)));
    chk({tag, ".kill"}, 64'(if_kill), 64'(m_drop && if_rvalid && !m_boot));
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
    if (lit_en) chk({tag, ".lit"}, 64'({act, if_kill}), 64'(lit));
    @(posedge clk);
    if (rst) begin
      if (m_boot) m_boot = 1'b0;
      else begin
        if (r inside {1, 2, 4, 5} && m_stall != '1) m_stall = m_stall + 64'd1;
        if (r == 3 && m_flush != '1) m_flush = m_flush + 64'd1;
        if (m_drop) begin
          if (r != 3 && if_rvalid) m_drop = 1'b0;
        end else if (r == 3 && if_busy && !if_rvalid) begin
          m_drop = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    mem_busy = 0; ex_busy = 0; ex_redirect = 0;
    id_rs1_rena = 0; id_rs2_rena = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    ex_mem_to_reg = 0; ex_rd_wena = 0; ex_rd_waddr = 0;
    if_busy = 0; if_rvalid = 1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    m_boot = 1; m_drop = 0; m_stall = '0; m_flush = '0;
    #2;
    chk("rst.codes", 64'({pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall}),
        64'({ZR, ZR, ZR, ZR, ZR}));
    chk("rst.cnt", stall_cnt | flush_cnt, 64'd0);
    tick("rst_hold", 1, L_BOOT);
    rst = 1'b1;
    tick("boot", 1, L_BOOT);
    tick("run0", 1, L_RUN);
    for (int i = 0; i < 3; i++) tick("run", 0, 11'd0);
    chk("run.stall_cnt", stall_cnt, 64'd0);

    // load into x5 read by rs2
    ex_mem_to_reg = 1; ex_rd_wena = 1; ex_rd_waddr = 5'd5;
    id_rs2_rena = 1; id_rs2_addr = 5'd5;
    tick("lu_rs2", 1, L_LU);
    chk("lu.stall_cnt", stall_cnt, 64'd1);
    ex_rd_waddr = 5'd0; id_rs2_addr = 5'd0;
    tick("lu_x0", 1, L_RUN);
    ex_rd_waddr = 5'd7; id_rs2_rena = 0; id_rs1_addr = 5'd7;
    tick("lu_rs1_off", 1, L_RUN);
    id_rs1_rena = 1;
    tick("lu_rs1", 1, L_LU);
    idle();

    // redirect held behind mem_busy, then accepted
    ex_redirect = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) tick("memb_redir", 1, L_MEMB);
    chk("memb.flush_cnt", flush_cnt, 64'd0);
    mem_busy = 0;
    tick("redir", 1, L_REDI);
    chk("redir.flush_cnt", flush_cnt, 64'd1);
    idle();
    ex_busy = 1;
    tick("exb", 1, L_EXB);
    ex_busy = 0; if_rvalid = 0;
    tick("fetch_wait", 1, L_WAIT);

    // redirect with fetch in flight enters DROP
    ex_redirect = 1; if_busy = 1; if_rvalid = 0;
    tick("drop_enter", 1, L_REDI);
    ex_redirect = 0;
    tick("drop_w1", 1, L_WAIT);
    tick("drop_w2", 1, L_WAIT);
    if_rvalid = 1; if_busy = 0;
    tick("drop_kill", 1, L_KILL);
    tick("drop_exit", 1, L_RUN);

    // redirect again while already dropping
    ex_redirect = 1; if_busy = 1; if_rvalid = 0;
    tick("drop2_enter", 0, 11'd0);
    tick("drop2_redir", 1, L_REDI);
    ex_redirect = 0; if_rvalid = 1; if_busy = 0;
    tick("drop2_kill", 1, L_KILL);
    tick("drop2_exit", 1, L_RUN);

    // counters at all-ones must not wrap
    force dut.stall_cnt = '1;
    force dut.flush_cnt = '1;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    m_stall = '1; m_flush = '1;
    mem_busy = 1;
    tick("sat_stall", 1, L_MEMB);
    chk("sat.stall_cnt", stall_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_busy = 0; ex_redirect = 1;
    tick("sat_flush", 1, L_REDI);
    chk("sat.flush_cnt", flush_cnt, 64'hFFFF_FFFF_FFFF_FFFF);

    // asynchronous reset in the middle of DROP
    ex_redirect = 1; if_busy = 1; if_rvalid = 0;
    tick("rdrop_enter", 1, L_REDI);
    ex_redirect = 0; if_rvalid = 1;
    #1 rst = 1'b0;
    #1;
    chk("arst.codes", 64'({pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall, if_kill}),
        64'(L_BOOT));
    chk("arst.stall_cnt", stall_cnt, 64'd0);
    chk("arst.flush_cnt", flush_cnt, 64'd0);
    m_boot = 1; m_drop = 0; m_stall = '0; m_flush = '0;
    tick("arst_hold", 1, L_BOOT);
    rst = 1'b1;
    tick("arst_boot", 1, L_BOOT);
    tick("arst_run", 1, L_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
